binary_decoder_2to4: RTL and testbench

//   Registered binary-to-one-hot decoder: N-bit select A drives exactly one of 2**N lines on I.

---
 rtl/binary_decoder_pkg.sv | 26 ++
 rtl/binary_decoder_core.sv | 30 +++
 rtl/binary_decoder_2to4.sv | 99 +++++++++
 tb/tb_binary_decoder_2to4.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/binary_decoder_pkg.sv
// ----------------------------------------------------------------------------
// binary_decoder_pkg
//   Shared constants and helpers for the registered binary-to-one-hot decoder.
//   DEC_N_DEFAULT : default select width (2 -> classic 2-to-4 decoder)
//   DEC_N_MAX     : widest supported select (6 -> 64 output lines)
//   DEC_W_MAX     : output width at DEC_N_MAX; onehot0() operates at this width
//   out_width(n)  : number of decoded lines for an n-bit select (2**n)
//   onehot0(vec)  : 1 when vec is all-zero or has exactly one bit set
// ----------------------------------------------------------------------------
package binary_decoder_pkg;

    localparam int DEC_N_DEFAULT = 2;
    localparam int DEC_N_MAX     = 6;
    localparam int DEC_W_MAX     = 1 << DEC_N_MAX;

    function automatic int out_width(input int n);
        return 1 << n;
    endfunction

    // Clearing the lowest set bit leaves zero only for a zero or one-hot
    // vector. Narrower callers zero-extend, which does not change the answer.
    function automatic logic onehot0(input logic [DEC_W_MAX-1:0] vec);
        return (vec & (vec - DEC_W_MAX'(1))) == '0;
    endfunction

endpackage

// File: rtl/binary_decoder_core.sv
// ----------------------------------------------------------------------------
// binary_decoder_core
//   Purely combinational decode of the select into the next-state one-hot
//   vector. The enclosing top level owns all registers.
//   Parameters:
//     N        select width (1..6)
//   Ports:
//     en       in   1            decode enable; 0 yields an all-zero vector
//     A        in   N            binary select
//     dec_next out  2**N         one-hot (or zero) next value for the output
// ----------------------------------------------------------------------------
module binary_decoder_core
    import binary_decoder_pkg::*;
#(
    parameter int N = DEC_N_DEFAULT
) (
    input  logic                    en,
    input  logic [N-1:0]            A,
    output logic [out_width(N)-1:0] dec_next
);

    // One comparator per output line: line gi is high only when the select
    // equals gi, so at most one line can be active for any defined A.
    generate
        for (genvar gi = 0; gi < out_width(N); gi++) begin : g_line
            assign dec_next[gi] = en && (A == N'(gi));
        end
    endgenerate

endmodule

// File: rtl/binary_decoder_2to4.sv
// ----------------------------------------------------------------------------
// binary_decoder_2to4
//   Registered binary-to-one-hot decoder. An N-bit select drives exactly one
//   of 2**N output lines one clock after it is sampled; with en low the
//   outputs clear on the next edge. Intended to feed chip selects / write
//   strobes, so the output comes straight from flops (glitch-free).
//   Parameters:
//     N        select width, 1..6 (default 2); output width is 2**N
//   Ports:
//     clk      in   1       rising-edge clock
//     rst_n    in   1       asynchronous active-low reset (sync release)
//     en       in   1       decode enable
//     A        in   N       binary select
//     I        out  2**N    registered one-hot output (or all-zero)
//     valid    out  1       registered copy of en
//     err      out  1       only with DECODER_ONEHOT_CHECK_EN defined: sticky
//                           flag set when the decode path produced a value
//                           that is neither zero nor one-hot
//   Build option:
//     DECODER_ONEHOT_CHECK_EN  adds the err port, its check logic and a
//                              simulation assertion on the same condition.
// ----------------------------------------------------------------------------
module binary_decoder_2to4
    import binary_decoder_pkg::*;
#(
    parameter int N = DEC_N_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [N-1:0]            A,
    output logic [out_width(N)-1:0] I,
    output logic                    valid
`ifdef DECODER_ONEHOT_CHECK_EN
    ,
    output logic                    err
`endif
);

    localparam int OUT_W = out_width(N);

    logic [OUT_W-1:0] dec_next;
    logic [OUT_W-1:0] i_reg;
    logic [OUT_W-1:0] i_next;
    logic             valid_reg;
    logic             valid_next;

    binary_decoder_core #(
        .N (N)
    ) u_core (
        .en       (en),
        .A        (A),
        .dec_next (dec_next)
    );

    always_comb begin
        i_next     = dec_next;
        valid_next = en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            i_reg     <= i_next;
            valid_reg <= valid_next;
        end
    end

    assign I     = i_reg;
    assign valid = valid_reg;

`ifdef DECODER_ONEHOT_CHECK_EN
    // The check looks at the value about to be loaded, so a corrupted decode
    // is flagged on the same edge that puts it on I.
    logic err_reg;
    logic err_next;

    always_comb begin
        err_next = err_reg | ~onehot0(DEC_W_MAX'(i_next));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err = err_reg;

    a_next_onehot0 : assert property (
        @(posedge clk) disable iff (!rst_n) onehot0(DEC_W_MAX'(i_next))
    );
`endif

endmodule

// File: tb/tb_binary_decoder_2to4.sv
// ----------------------------------------------------------------------------
// tb_binary_decoder_2to4
//   Drives a default (N=2) and an N=3 decoder with the same enable. Each
//   stimulus cycle pushes the expected response of both into scoreboards;
//   a monitor pops and compares one entry per clock after the edge.
//   Reset behaviour is checked directly between clock edges.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_binary_decoder_2to4;

    typedef struct {
        logic       v;
        logic [7:0] i;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] a2;
    logic [2:0] a3;
    logic [3:0] i2;
    logic [7:0] i3;
    logic       valid2;
    logic       valid3;
`ifdef DECODER_ONEHOT_CHECK_EN
    logic       err2;
    logic       err3;
`endif

    exp_t q2[$];
    exp_t q3[$];

    int   checks;
    int   errors;
    int   txn;
    bit   mon_en;

    binary_decoder_2to4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (a2),
        .I     (i2),
        .valid (valid2)
`ifdef DECODER_ONEHOT_CHECK_EN
        ,
        .err   (err2)
`endif
    );

    binary_decoder_2to4 #(.N(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (a3),
        .I     (i3),
        .valid (valid3)
`ifdef DECODER_ONEHOT_CHECK_EN
        ,
        .err   (err3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: decoded line number equals the select value.
    function automatic exp_t model(input bit e, input int sel);
        exp_t r;
        r.v = e;
        r.i = e ? 8'(1 << sel) : 8'h00;
        return r;
    endfunction

    task automatic apply(input bit e, input int s2, input int s3);
        en = e;
        a2 = 2'(s2);
        a3 = 3'(s3);
        q2.push_back(model(e, s2));
        q3.push_back(model(e, s3));
    endtask

    task automatic drive(input bit e, input int s2, input int s3);
        @(negedge clk);
        apply(e, s2, s3);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q2.size() != 0 || q3.size() != 0) && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain", 64'(q2.size() + q3.size()), 64'd0);
    endtask

    // Monitor: one expected entry per clock while enabled.
    initial begin
        exp_t e2;
        exp_t e3;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (q2.size() == 0 || q3.size() == 0) begin
                    check("scoreboard_underflow", 64'(q2.size() + q3.size()), 64'd2);
                end else begin
                    e2 = q2.pop_front();
                    e3 = q3.pop_front();
                    txn++;
                    $display("txn %0d: en=%0b A=%0d I=%b valid=%0b | A3=%0d I3=%b valid3=%0b",
                             txn, en, a2, i2, valid2, a3, i3, valid3);
                    check("n2_I", 64'(i2), 64'(e2.i[3:0]));
                    check("n2_valid", 64'(valid2), 64'(e2.v));
                    check("n3_I", 64'(i3), 64'(e3.i));
                    check("n3_valid", 64'(valid3), 64'(e3.v));
                end
            end
        end
    end

    initial begin
        int s2_tab[8];
        int e_tab[8];
        checks = 0;
        errors = 0;
        txn    = 0;
        mon_en = 1'b0;

        // Reset asserted from time zero with a live select: no edge needed.
        rst_n = 1'b0;
        en    = 1'b1;
        a2    = 2'd3;
        a3    = 3'd7;
        #1;
        check("reset_I", 64'(i2), 64'd0);
        check("reset_valid", 64'(valid2), 64'd0);
        check("reset_I3", 64'(i3), 64'd0);
        // Held through an edge.
        @(posedge clk);
        @(negedge clk);
        check("reset_hold_I", 64'(i2), 64'd0);
        check("reset_hold_valid", 64'(valid2), 64'd0);

        // Release and run directed sequence: sweep, then enable drop/restore.
        // N=3 instance sweeps all eight codes (5 first) alongside.
        s2_tab = '{0, 1, 3, 2, 2, 0, 2, 1};
        e_tab  = '{1, 1, 1, 1, 1, 0, 1, 1};
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        apply(1'b1, s2_tab[0], 5);
        for (int k = 1; k < 8; k++) begin
            drive(e_tab[k] != 0, s2_tab[k], (5 + k) % 8);
        end
        drive(1'b0, 3, 7);
        drive(1'b1, 3, 0);

        // Randomized back-to-back traffic.
        for (int k = 0; k < 120; k++) begin
            drive($urandom_range(0, 4) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        end

        // Async reset between edges while I=1000.
        drive(1'b1, 3, 7);
        wait_drain();
        check("pre_reset_I", 64'(i2), 64'h8);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_reset_I", 64'(i2), 64'd0);
        check("async_reset_valid", 64'(valid2), 64'd0);
        check("async_reset_I3", 64'(i3), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        apply(1'b1, 1, 2);
        drive(1'b1, 2, 6);
        @(negedge clk);
        en = 1'b0;
        wait_drain();
        mon_en = 1'b0;

`ifdef DECODER_ONEHOT_CHECK_EN
        // Corrupt the decode path and check the sticky error flag.
        check("err_clear", 64'(err2), 64'd0);
        $assertoff;
        @(negedge clk);
        force dut.dec_next = 4'b0011;
        @(posedge clk);
        #1;
        check("err_set", 64'(err2), 64'd1);
        check("err_other_inst", 64'(err3), 64'd0);
        @(negedge clk);
        release dut.dec_next;
        $asserton;
        en = 1'b1;
        a2 = 2'd1;
        @(posedge clk);
        #1;
        check("err_sticky", 64'(err2), 64'd1);
        check("err_sticky_I", 64'(i2), 64'h2);
        rst_n = 1'b0;
        #1;
        check("err_reset", 64'(err2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
